// File: rtl/clint_timer_pkg.sv
// Shared CLINT definitions: register offsets, mtimecmp reset value, decode and byte-merge helpers.
package clint_timer_pkg;

  localparam logic [15:0] CLINT_MSIP_OFF        = 16'h0000;
  localparam logic [15:0] CLINT_MTIMECMP_LO_OFF = 16'h4000;
  localparam logic [15:0] CLINT_MTIMECMP_HI_OFF = 16'h4004;
  localparam logic [15:0] CLINT_MTIME_LO_OFF    = 16'hBFF8;
  localparam logic [15:0] CLINT_MTIME_HI_OFF    = 16'hBFFC;

  localparam logic [63:0] CLINT_MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_MSIP,
    SEL_CMP_LO,
    SEL_CMP_HI,
    SEL_MTIME_LO,
    SEL_MTIME_HI
  } clint_sel_e;

  typedef enum logic {
    RSP_EMPTY,
    RSP_FULL
  } clint_rsp_state_e;

  // Offsets are exact word addresses, so any address with low bits set falls to SEL_NONE.
  function automatic clint_sel_e clint_decode(input logic [15:0] off);
    case (off)
      CLINT_MSIP_OFF:        return SEL_MSIP;
      CLINT_MTIMECMP_LO_OFF: return SEL_CMP_LO;
      CLINT_MTIMECMP_HI_OFF: return SEL_CMP_HI;
      CLINT_MTIME_LO_OFF:    return SEL_MTIME_LO;
      CLINT_MTIME_HI_OFF:    return SEL_MTIME_HI;
      default:               return SEL_NONE;
    endcase
  endfunction

  function automatic logic [31:0] clint_merge(input logic [31:0] cur,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  wstrb);
    logic [31:0] res;
    res = cur;
    for (int unsigned b = 0; b < 4; b++) begin
      if (wstrb[b]) res[8*b +: 8] = wdata[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/clint_prescaler.sv
// Divides clk by TICK_DIV to produce the mtime increment strobe; hold freezes the count.
module clint_prescaler #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic hold,
  output logic tick
);

  localparam logic [15:0] LAST = 16'(TICK_DIV - 1);

  logic [15:0] cnt_q;

  assign tick = !hold && (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (!hold) begin
      cnt_q <= tick ? '0 : cnt_q + 16'd1;
    end
  end

endmodule

// File: rtl/clint_timer.sv
// Single-hart CLINT: mtime/mtimecmp/msip behind a valid/ready bus with a one-entry response buffer.
// Optional: define CLINT_MTIME_SNAPSHOT_EN to latch mtime[63:32] on an mtime[31:0] read.
module clint_timer
  import clint_timer_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1,
  parameter int unsigned ADDR_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              durdur_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [31:0]       req_wdata_i,
  input  logic [3:0]        req_wstrb_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [31:0]       rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              timer_interrupt_o,
  output logic              software_interrupt_o
);

  logic [63:0]      mtime_q, mtime_d;
  logic [63:0]      mtimecmp_q, mtimecmp_d;
  logic             msip_q, msip_d;
  logic             tick;
  logic [15:0]      off;
  clint_sel_e       sel;
  logic             acc, err, rd, wr, wr_any;
  logic [31:0]      rdata_d;
  clint_rsp_state_e rsp_state_q, rsp_state_d;

  clint_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clk (clk),
    .rst (rst),
    .hold(durdur_i),
    .tick(tick)
  );

  assign off    = 16'(req_addr_i);
  assign sel    = clint_decode(off);
  assign err    = (sel == SEL_NONE);
  assign acc    = req_valid_i && req_ready_o;
  assign rd     = acc && !req_we_i && !err;
  assign wr     = acc && req_we_i && !err;
  assign wr_any = |req_wstrb_i;

  assign rsp_valid_o          = (rsp_state_q == RSP_FULL);
  assign req_ready_o          = !rsp_valid_o || rsp_ready_i;
  assign software_interrupt_o = msip_q;

`ifdef CLINT_MTIME_SNAPSHOT_EN
  logic [31:0] shadow_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      shadow_q <= '0;
    end else if (rd && sel == SEL_MTIME_LO) begin
      shadow_q <= mtime_q[63:32];
    end else if (wr && wr_any && sel == SEL_MTIME_HI) begin
      shadow_q <= mtime_d[63:32];
    end
  end
`endif

  // Read mux uses pre-update register values.
  always_comb begin
    rdata_d = '0;
    case (sel)
      SEL_MSIP:     rdata_d = {31'd0, msip_q};
      SEL_CMP_LO:   rdata_d = mtimecmp_q[31:0];
      SEL_CMP_HI:   rdata_d = mtimecmp_q[63:32];
      SEL_MTIME_LO: rdata_d = mtime_q[31:0];
`ifdef CLINT_MTIME_SNAPSHOT_EN
      SEL_MTIME_HI: rdata_d = shadow_q;
`else
      SEL_MTIME_HI: rdata_d = mtime_q[63:32];
`endif
      default:      rdata_d = '0;
    endcase
  end

  // A write to either mtime half replaces the increment for the whole 64-bit value.
  always_comb begin
    mtime_d    = mtime_q;
    mtimecmp_d = mtimecmp_q;
    msip_d     = msip_q;
    if (wr && wr_any && sel == SEL_MTIME_LO) begin
      mtime_d[31:0] = clint_merge(mtime_q[31:0], req_wdata_i, req_wstrb_i);
    end else if (wr && wr_any && sel == SEL_MTIME_HI) begin
      mtime_d[63:32] = clint_merge(mtime_q[63:32], req_wdata_i, req_wstrb_i);
    end else if (tick) begin
      mtime_d = mtime_q + 64'd1;
    end
    if (wr && sel == SEL_CMP_LO) begin
      mtimecmp_d[31:0] = clint_merge(mtimecmp_q[31:0], req_wdata_i, req_wstrb_i);
    end
    if (wr && sel == SEL_CMP_HI) begin
      mtimecmp_d[63:32] = clint_merge(mtimecmp_q[63:32], req_wdata_i, req_wstrb_i);
    end
    if (wr && sel == SEL_MSIP && req_wstrb_i[0]) begin
      msip_d = req_wdata_i[0];
    end
  end

  always_comb begin
    rsp_state_d = rsp_state_q;
    if (acc) begin
      rsp_state_d = RSP_FULL;
    end else if (rsp_ready_i) begin
      rsp_state_d = RSP_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rsp_state_q <= RSP_EMPTY;
    end else begin
      rsp_state_q <= rsp_state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mtime_q           <= '0;
      mtimecmp_q        <= CLINT_MTIMECMP_RST;
      msip_q            <= 1'b0;
      timer_interrupt_o <= 1'b0;
      rsp_rdata_o       <= '0;
      rsp_err_o         <= 1'b0;
    end else begin
      mtime_q           <= mtime_d;
      mtimecmp_q        <= mtimecmp_d;
      msip_q            <= msip_d;
      timer_interrupt_o <= (mtime_q >= mtimecmp_q);
      if (acc) begin
        rsp_rdata_o <= rd ? rdata_d : '0;
        rsp_err_o   <= err;
      end
    end
  end

endmodule

// File: tb/tb_clint_timer.sv
// Scoreboard bench for clint_timer: behavioural register model pushes expected responses, monitor pops.
module tb_clint_timer;

  localparam int unsigned TD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        durdur_i = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_we_i = 1'b0;
  logic [15:0] req_addr_i = '0;
  logic [31:0] req_wdata_i = '0;
  logic [3:0]  req_wstrb_i = '0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b1;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        timer_interrupt_o;
  logic        software_interrupt_o;

  clint_timer #(
    .TICK_DIV(TD),
    .ADDR_W  (16)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .durdur_i            (durdur_i),
    .req_valid_i         (req_valid_i),
    .req_ready_o         (req_ready_o),
    .req_we_i            (req_we_i),
    .req_addr_i          (req_addr_i),
    .req_wdata_i         (req_wdata_i),
    .req_wstrb_i         (req_wstrb_i),
    .rsp_valid_o         (rsp_valid_o),
    .rsp_ready_i         (rsp_ready_i),
    .rsp_rdata_o         (rsp_rdata_o),
    .rsp_err_o           (rsp_err_o),
    .timer_interrupt_o   (timer_interrupt_o),
    .software_interrupt_o(software_interrupt_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } rsp_t;

  rsp_t        sb_q[$];
  int          checks = 0;
  int          failures = 0;
  logic [63:0] m_mtime, m_cmp;
  logic        m_msip, m_tirq, m_pend, m_acc;
  logic        started = 1'b0;
  logic        rand_rdy = 1'b0;
  int unsigned m_active;
`ifdef CLINT_MTIME_SNAPSHOT_EN
  logic [31:0] m_shadow;
`endif

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] bytes_upd(input logic [31:0] cur, input logic [31:0] d,
                                            input logic [3:0] s);
    logic [31:0] mask;
    mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (cur & ~mask) | (d & mask);
  endfunction

  // Reference model: one step per clock edge, from the register-map rules.
  task automatic model_step();
    logic        err, tick, mt_wr;
    logic [31:0] rd;
    logic [63:0] nxt_mtime;
    if (!rst) begin
      m_mtime = 64'd0; m_cmp = '1; m_msip = 1'b0; m_tirq = 1'b0;
      m_pend = 1'b0; m_acc = 1'b0; m_active = 0; sb_q.delete();
`ifdef CLINT_MTIME_SNAPSHOT_EN
      m_shadow = '0;
`endif
      started = 1'b1;
      return;
    end
    m_acc = req_valid_i && (!m_pend || rsp_ready_i);
    tick = !durdur_i && (m_active % TD == TD - 1);
    if (!durdur_i) m_active++;
    nxt_mtime = tick ? m_mtime + 64'd1 : m_mtime;
    m_tirq = (m_mtime >= m_cmp);
    if (m_acc) begin
      err = (req_addr_i[1:0] != 2'b00) ||
            !(req_addr_i inside {16'h0000, 16'h4000, 16'h4004, 16'hBFF8, 16'hBFFC});
      rd = '0;
      mt_wr = 1'b0;
      if (!err && !req_we_i) begin
        case (req_addr_i)
          16'h0000: rd = {31'd0, m_msip};
          16'h4000: rd = m_cmp[31:0];
          16'h4004: rd = m_cmp[63:32];
          16'hBFF8: rd = m_mtime[31:0];
`ifdef CLINT_MTIME_SNAPSHOT_EN
          16'hBFFC: rd = m_shadow;
`else
          16'hBFFC: rd = m_mtime[63:32];
`endif
          default: rd = '0;
        endcase
`ifdef CLINT_MTIME_SNAPSHOT_EN
        if (req_addr_i == 16'hBFF8) m_shadow = m_mtime[63:32];
`endif
      end
      if (!err && req_we_i) begin
        case (req_addr_i)
          16'h0000: if (req_wstrb_i[0]) m_msip = req_wdata_i[0];
          16'h4000: m_cmp[31:0]  = bytes_upd(m_cmp[31:0], req_wdata_i, req_wstrb_i);
          16'h4004: m_cmp[63:32] = bytes_upd(m_cmp[63:32], req_wdata_i, req_wstrb_i);
          16'hBFF8: if (req_wstrb_i != 4'h0) begin
            nxt_mtime = {m_mtime[63:32], bytes_upd(m_mtime[31:0], req_wdata_i, req_wstrb_i)};
            mt_wr = 1'b1;
          end
          16'hBFFC: if (req_wstrb_i != 4'h0) begin
            nxt_mtime = {bytes_upd(m_mtime[63:32], req_wdata_i, req_wstrb_i), m_mtime[31:0]};
            mt_wr = 1'b1;
          end
          default: ;
        endcase
`ifdef CLINT_MTIME_SNAPSHOT_EN
        if (mt_wr && req_addr_i == 16'hBFFC) m_shadow = nxt_mtime[63:32];
`endif
      end
      sb_q.push_back('{err: err, rdata: (req_we_i || err) ? 32'd0 : rd});
    end
    m_mtime = nxt_mtime;
    m_pend = m_acc ? 1'b1 : (rsp_ready_i ? 1'b0 : m_pend);
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Monitor: compares outputs on the falling edge, pops the scoreboard on each consumed response.
  initial forever begin
    @(negedge clk);
    if (started) begin
      chk("req_ready", {63'd0, req_ready_o}, {63'd0, !m_pend || rsp_ready_i});
      chk("timer_irq", {63'd0, timer_interrupt_o}, {63'd0, m_tirq});
      chk("sw_irq", {63'd0, software_interrupt_o}, {63'd0, m_msip});
      if (m_pend) begin
        chk("rsp_valid", {63'd0, rsp_valid_o}, 64'd1);
        if (sb_q.size() == 0) begin
          chk("sb_underflow", 64'd1, 64'd0);
        end else begin
          chk("rsp_rdata", {32'd0, rsp_rdata_o}, {32'd0, sb_q[0].rdata});
          chk("rsp_err", {63'd0, rsp_err_o}, {63'd0, sb_q[0].err});
          if (rsp_ready_i) void'(sb_q.pop_front());
        end
      end else begin
        chk("rsp_valid", {63'd0, rsp_valid_o}, 64'd0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_rdy) rsp_ready_i = ($urandom_range(0, 3) != 0);
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step();
  endtask

  task automatic do_req(input logic we, input logic [15:0] a, input logic [31:0] d,
                        input logic [3:0] s);
    req_valid_i = 1'b1; req_we_i = we; req_addr_i = a; req_wdata_i = d; req_wstrb_i = s;
    for (int n = 0; n < 64; n++) begin
      step();
      if (m_acc) begin
        req_valid_i = 1'b0;
        return;
      end
    end
    chk("req_timeout", 64'd1, 64'd0);
    req_valid_i = 1'b0;
  endtask

  initial begin
    logic [15:0] addrs [9];
    addrs = '{16'h0000, 16'h4000, 16'h4004, 16'hBFF8, 16'hBFFC,
              16'h0002, 16'h1000, 16'hBFFA, 16'h4008};

    idle(3);
    rst = 1'b1;
    idle(1);
    chk("reset_rdata", {32'd0, rsp_rdata_o}, 64'd0);
    chk("reset_err", {63'd0, rsp_err_o}, 64'd0);

    do_req(1'b0, 16'h4000, '0, 4'h0);
    do_req(1'b0, 16'h4004, '0, 4'h0);
    do_req(1'b0, 16'h0000, '0, 4'h0);
    do_req(1'b1, 16'h4000, 32'hAABBCCDD, 4'b0010);
    do_req(1'b0, 16'h4000, '0, 4'h0);
    do_req(1'b1, 16'h4000, 32'h0000_0010, 4'hF);
    do_req(1'b1, 16'h4004, 32'h0, 4'hF);
    idle(80);
    chk("tirq_rise", {63'd0, timer_interrupt_o}, 64'd1);
    do_req(1'b1, 16'h4000, 32'h0000_0100, 4'hF);
    idle(3);

    do_req(1'b1, 16'h0000, 32'h3, 4'hF);
    do_req(1'b0, 16'h0000, '0, 4'h0);
    do_req(1'b1, 16'h0000, 32'h0, 4'hF);
    do_req(1'b0, 16'h0002, '0, 4'h0);
    do_req(1'b0, 16'h1000, '0, 4'h0);
    do_req(1'b1, 16'h1000, 32'hFFFF_FFFF, 4'hF);
    do_req(1'b1, 16'h4006, 32'hFFFF_FFFF, 4'hF);

    do_req(1'b1, 16'hBFF8, 32'hFFFF_FFFF, 4'hF);
    do_req(1'b1, 16'hBFFC, 32'h0, 4'hF);
    idle(6);
    do_req(1'b0, 16'hBFF8, '0, 4'h0);
    do_req(1'b0, 16'hBFFC, '0, 4'h0);

    do_req(1'b1, 16'hBFF8, 32'hFFFF_FFFE, 4'hF);
    do_req(1'b1, 16'hBFFC, 32'h0, 4'hF);
    do_req(1'b0, 16'hBFF8, '0, 4'h0);
    idle(8);
    do_req(1'b0, 16'hBFFC, '0, 4'h0);

    idle(2);
    rsp_ready_i = 1'b0;
    do_req(1'b0, 16'hBFF8, '0, 4'h0);
    req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = 16'h4004;
    idle(5);
    chk("stall_ready", {63'd0, req_ready_o}, 64'd0);
    rsp_ready_i = 1'b1;
    do_req(1'b0, 16'h4004, '0, 4'h0);

    durdur_i = 1'b1;
    do_req(1'b0, 16'hBFF8, '0, 4'h0);
    idle(10);
    do_req(1'b0, 16'hBFF8, '0, 4'h0);
    durdur_i = 1'b0;
    idle(3);

    rand_rdy = 1'b1;
    for (int i = 0; i < 400; i++) begin
      durdur_i = ($urandom_range(0, 7) == 0);
      do_req(1'(($urandom_range(0, 2) == 0)), addrs[$urandom_range(0, 8)],
             $urandom(), 4'($urandom_range(0, 15)));
      idle($urandom_range(0, 2));
    end
    rand_rdy = 1'b0;
    durdur_i = 1'b0;
    rsp_ready_i = 1'b1;
    idle(3);

    rsp_ready_i = 1'b0;
    do_req(1'b0, 16'hBFF8, '0, 4'h0);
    idle(1);
    rst = 1'b0;
    idle(2);
    rst = 1'b1;
    rsp_ready_i = 1'b1;
    idle(1);
    chk("post_reset_valid", {63'd0, rsp_valid_o}, 64'd0);
    do_req(1'b0, 16'h4000, '0, 4'h0);
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
